// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch FSM feeding a UART TX controller.
// Bytes are popped only when the transmitter is idle and launched with a one-cycle valid.
module uart_tx_feeder #(
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  clr_flags,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow,
   output logic                  tx_err,
   input  logic                  tx_busy,
   output logic                  tx_data_valid,
   output logic [DATA_WIDTH-1:0] tx_p_data
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t state, state_nx;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic [TW-1:0]         to_cnt, to_cnt_nx;
   logic                  push, pop, err_set;

   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);
   assign fill_level = count;
   assign push       = wr_en & ~full;

   assign tx_data_valid = (state == LAUNCH);

   always_comb begin
      state_nx  = state;
      to_cnt_nx = to_cnt;
      err_set   = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               state_nx = LAUNCH;
               pop      = 1'b1;
            end
         end
         LAUNCH: begin
            state_nx  = WAIT_BUSY;
            to_cnt_nx = '0;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nx = WAIT_DONE;
            end else if (to_cnt == TO_LAST) begin
               // transmitter never took the byte; drop it and move on
               err_set  = 1'b1;
               state_nx = IDLE;
            end else begin
               to_cnt_nx = to_cnt + TW'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         to_cnt <= '0;
      end else begin
         state  <= state_nx;
         to_cnt <= to_cnt_nx;
      end
   end

   // storage needs no reset: pointers and count define what is valid
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         tx_p_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (pop) begin
            rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
            tx_p_data <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // a set event in the same cycle as clr_flags wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         tx_err   <= 1'b0;
      end else begin
         overflow <= (wr_en & full) | (overflow & ~clr_flags);
         tx_err   <= err_set | (tx_err & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small UART TX busy model.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
module tb_uart_tx_feeder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       clr_flags = 1'b0;
   logic       full, empty, overflow, tx_err;
   logic [3:0] fill_level;
   logic       tx_busy = 1'b0;
   logic       tx_data_valid;
   logic [7:0] tx_p_data;

   int nvec = 0;
   int nerr = 0;

   // TX model state; mode 0 normal, 1 never busy, 2 busy held high
   int         mode = 0;
   int         busy_len = 20;
   int         bcnt = 0;
   int         cyc = 0;
   int         nvalid = 0;
   logic [7:0] logq[$];
   int         vtime[$];
   int         ftime[$];

   uart_tx_feeder dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .clr_flags(clr_flags),
      .full(full),
      .empty(empty),
      .fill_level(fill_level),
      .overflow(overflow),
      .tx_err(tx_err),
      .tx_busy(tx_busy),
      .tx_data_valid(tx_data_valid),
      .tx_p_data(tx_p_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         tx_busy = 1'b0;
         bcnt = 0;
      end else begin
         if (tx_data_valid) begin
            logq.push_back(tx_p_data);
            vtime.push_back(cyc);
            nvalid++;
         end
         case (mode)
            0: begin
               if (tx_data_valid) begin
                  tx_busy = 1'b1;
                  bcnt = busy_len;
               end else if (tx_busy) begin
                  if (bcnt <= 1) begin
                     tx_busy = 1'b0;
                     ftime.push_back(cyc);
                  end else begin
                     bcnt--;
                  end
               end
            end
            1: tx_busy = 1'b0;
            default: tx_busy = 1'b1;
         endcase
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_en = 1'b0;
      clr_flags = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #1;
      nvec++;
      if ({full, empty, fill_level, overflow, tx_err, tx_data_valid, tx_p_data}
          !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         $display("FAIL reset_outputs: got f=%b e=%b lvl=%0d ov=%b err=%b v=%b d=%h",
                  full, empty, fill_level, overflow, tx_err, tx_data_valid, tx_p_data);
         nerr++;
      end
      do_reset();
   endtask

   task automatic test_single();
      int b, nv;
      do_reset();
      mode = 0;
      busy_len = 20;
      b = logq.size();
      nv = nvalid;
      wr_data = 8'hA5;
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      nvec++;
      if (tx_data_valid !== 1'b0 || empty !== 1'b0) begin
         $display("FAIL single_e0: got v=%b e=%b exp v=0 e=0", tx_data_valid, empty);
         nerr++;
      end
      step();
      nvec++;
      if (tx_data_valid !== 1'b1 || tx_p_data !== 8'hA5) begin
         $display("FAIL single_launch: got v=%b d=%h exp v=1 d=a5", tx_data_valid, tx_p_data);
         nerr++;
      end
      step();
      for (int k = 0; k < 40 && tx_busy; k++) begin
         nvec++;
         if (tx_p_data !== 8'hA5 || tx_data_valid !== 1'b0) begin
            $display("FAIL single_hold: got d=%h v=%b exp d=a5 v=0", tx_p_data, tx_data_valid);
            nerr++;
         end
         step();
      end
      step();
      step();
      nvec++;
      if (empty !== 1'b1 || nvalid - nv != 1 || logq.size() - b != 1) begin
         $display("FAIL single_end: got empty=%b pulses=%0d exp empty=1 pulses=1",
                  empty, nvalid - nv);
         nerr++;
      end
   endtask

   task automatic test_burst();
      int b, fb;
      do_reset();
      mode = 0;
      busy_len = 10;
      b = logq.size();
      fb = ftime.size();
      for (int i = 1; i <= 8; i++) begin
         wr_data = 8'(i);
         wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      nvec++;
      if (fill_level !== 4'd7 || full !== 1'b0) begin
         $display("FAIL burst_level: got lvl=%0d full=%b exp lvl=7 full=0", fill_level, full);
         nerr++;
      end
      for (int k = 0; k < 400 && logq.size() - b < 8; k++) step();
      nvec++;
      if (logq.size() - b != 8) begin
         $display("FAIL burst_count: got %0d exp 8", logq.size() - b);
         nerr++;
      end else begin
         for (int i = 0; i < 8; i++) begin
            nvec++;
            if (logq[b+i] !== 8'(i + 1)) begin
               $display("FAIL burst_order[%0d]: got %h exp %h", i, logq[b+i], 8'(i + 1));
               nerr++;
            end
         end
         for (int i = 1; i < 8; i++) begin
            nvec++;
            if (ftime.size() < fb + i || vtime[b+i] - ftime[fb+i-1] != 2) begin
               $display("FAIL burst_gap[%0d]: got valid %0d cycles after busy fall exp 2",
                        i, (ftime.size() >= fb + i) ? vtime[b+i] - ftime[fb+i-1] : -1);
               nerr++;
            end
         end
      end
   endtask

   task automatic test_overflow();
      int b, nv;
      do_reset();
      mode = 2;
      step();
      b = logq.size();
      nv = nvalid;
      for (int i = 0; i < 9; i++) begin
         wr_data = 8'h10 + 8'(i);
         wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      nvec++;
      if (fill_level !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || nvalid != nv) begin
         $display("FAIL ovf_state: got lvl=%0d full=%b ov=%b launches=%0d exp 8 1 1 0",
                  fill_level, full, overflow, nvalid - nv);
         nerr++;
      end
      wr_data = 8'h55;
      wr_en = 1'b1;
      clr_flags = 1'b1;
      step();
      wr_en = 1'b0;
      clr_flags = 1'b0;
      nvec++;
      if (overflow !== 1'b1 || fill_level !== 4'd8) begin
         $display("FAIL ovf_set_wins: got ov=%b lvl=%0d exp ov=1 lvl=8", overflow, fill_level);
         nerr++;
      end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      nvec++;
      if (overflow !== 1'b0) begin
         $display("FAIL ovf_clear: got %b exp 0", overflow);
         nerr++;
      end
      busy_len = 3;
      mode = 0;
      for (int k = 0; k < 400 && logq.size() - b < 8; k++) step();
      for (int k = 0; k < 20; k++) step();
      nvec++;
      if (logq.size() - b != 8 || empty !== 1'b1) begin
         $display("FAIL ovf_drain: got %0d bytes empty=%b exp 8 empty=1",
                  logq.size() - b, empty);
         nerr++;
      end else begin
         for (int i = 0; i < 8; i++) begin
            nvec++;
            if (logq[b+i] !== 8'h10 + 8'(i)) begin
               $display("FAIL ovf_data[%0d]: got %h exp %h", i, logq[b+i], 8'h10 + 8'(i));
               nerr++;
            end
         end
      end
   endtask

   task automatic test_wrap();
      int b;
      logic [7:0] n;
      do_reset();
      mode = 0;
      busy_len = 2;
      b = logq.size();
      n = 8'h00;
      for (int it = 0; it < 20; it++) begin
         for (int j = 0; j < 3; j++) begin
            wr_data = n;
            wr_en = 1'b1;
            n++;
            step();
         end
         wr_en = 1'b0;
         for (int k = 0; k < 200 && logq.size() - b < 3 * (it + 1); k++) step();
      end
      for (int k = 0; k < 10; k++) step();
      nvec++;
      if (logq.size() - b != 60) begin
         $display("FAIL wrap_count: got %0d exp 60", logq.size() - b);
         nerr++;
      end else begin
         for (int i = 0; i < 60; i++) begin
            nvec++;
            if (logq[b+i] !== 8'(i)) begin
               $display("FAIL wrap_data[%0d]: got %h exp %h", i, logq[b+i], 8'(i));
               nerr++;
            end
         end
      end
   endtask

   task automatic test_timeout();
      int b;
      do_reset();
      mode = 1;
      b = logq.size();
      wr_data = 8'h3C;
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      step();
      nvec++;
      if (tx_data_valid !== 1'b1 || tx_p_data !== 8'h3C) begin
         $display("FAIL tmo_launch: got v=%b d=%h exp v=1 d=3c", tx_data_valid, tx_p_data);
         nerr++;
      end
      for (int k = 0; k < 4; k++) step();
      nvec++;
      if (tx_err !== 1'b0) begin
         $display("FAIL tmo_early: got tx_err=%b exp 0", tx_err);
         nerr++;
      end
      step();
      nvec++;
      if (tx_err !== 1'b1 || tx_data_valid !== 1'b0) begin
         $display("FAIL tmo_err: got tx_err=%b v=%b exp 1 0", tx_err, tx_data_valid);
         nerr++;
      end
      mode = 0;
      busy_len = 3;
      wr_data = 8'h3D;
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      for (int k = 0; k < 50 && logq.size() - b < 2; k++) step();
      nvec++;
      if (logq.size() - b != 2 || logq[logq.size()-1] !== 8'h3D || tx_err !== 1'b1) begin
         $display("FAIL tmo_next: got %0d bytes err=%b exp 2 bytes last 3d err=1",
                  logq.size() - b, tx_err);
         nerr++;
      end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      nvec++;
      if (tx_err !== 1'b0) begin
         $display("FAIL tmo_clear: got %b exp 0", tx_err);
         nerr++;
      end
   endtask

   task automatic test_reset_mid();
      int b, nv;
      do_reset();
      mode = 0;
      busy_len = 30;
      for (int i = 0; i < 5; i++) begin
         wr_data = 8'h60 + 8'(i);
         wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      step();
      nvec++;
      if (fill_level !== 4'd4 || tx_busy !== 1'b1 || tx_p_data !== 8'h60) begin
         $display("FAIL mid_pre: got lvl=%0d busy=%b d=%h exp 4 1 60",
                  fill_level, tx_busy, tx_p_data);
         nerr++;
      end
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({full, empty, fill_level, overflow, tx_err, tx_data_valid, tx_p_data}
          !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         $display("FAIL mid_async: got f=%b e=%b lvl=%0d ov=%b err=%b v=%b d=%h",
                  full, empty, fill_level, overflow, tx_err, tx_data_valid, tx_p_data);
         nerr++;
      end
      step();
      step();
      rst_n = 1'b1;
      nv = nvalid;
      b = logq.size();
      for (int k = 0; k < 20; k++) step();
      nvec++;
      if (nvalid != nv || empty !== 1'b1) begin
         $display("FAIL mid_quiet: got %0d launches empty=%b exp 0 1", nvalid - nv, empty);
         nerr++;
      end
      wr_data = 8'h77;
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      for (int k = 0; k < 20 && logq.size() == b; k++) step();
      nvec++;
      if (logq.size() - b != 1 || logq[logq.size()-1] !== 8'h77) begin
         $display("FAIL mid_new: got %0d bytes exp one byte 77", logq.size() - b);
         nerr++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_wrap();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte FIFO plus launch FSM placed directly upstream of the UART TX controller.
- Accepts bytes from the system side with a write strobe and holds them until the UART TX is idle.
- Hands each byte over with a one-cycle Data_Valid pulse and a stable parallel data bus, then waits for the TX busy cycle to complete.
- Decouples bursty register/DMA writes from serial frame timing.

Parameters:
DATA_WIDTH, 8, width of one UART data word.
DEPTH, 8, FIFO entries; must be a power of two, at least 2.
ADDR_WIDTH, 3, log2(DEPTH).
BUSY_TIMEOUT, 4, cycles allowed in WAIT_BUSY for tx_busy to rise before the launch is declared failed.

Ports:
clk  in  1  system clock, all logic on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
wr_en  in  1  write strobe; pushes wr_data when not full.
wr_data  in  DATA_WIDTH  byte to enqueue.
clr_flags  in  1  synchronous clear of overflow and tx_err.
full  out  1  FIFO holds DEPTH entries.
empty  out  1  FIFO holds 0 entries.
fill_level  out  ADDR_WIDTH+1  current entry count, 0..DEPTH.
overflow  out  1  sticky; a write was dropped because the FIFO was full.
tx_err  out  1  sticky; tx_busy did not rise within BUSY_TIMEOUT after a launch.
tx_busy  in  1  busy from the UART TX controller.
tx_data_valid  out  1  one-cycle launch pulse to the UART TX Data_Valid.
tx_p_data  out  DATA_WIDTH  byte presented to the UART TX; registered.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers and count go to 0; state goes to IDLE.
  - full=0, empty=1, fill_level=0, overflow=0, tx_err=0, tx_data_valid=0, tx_p_data=0.
- FIFO:
  - Circular buffer with ADDR_WIDTH-bit read/write pointers that wrap DEPTH-1 -> 0.
  - Count register is DEPTH-capable; full, empty and fill_level decode from registered count, so they are valid one cycle after the edge.
- Write:
  - At an edge with wr_en=1 and full=0, wr_data is stored at the write pointer; the write pointer increments.
  - wr_en=1 with full=1 drops the data; overflow sets and pointers are unchanged.
  - A pop in the same cycle does not rescue a write while full=1.
- Pop:
  - Occurs only on the IDLE->LAUNCH transition, which loads tx_p_data from the head and increments the read pointer.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if empty=0 and tx_busy=0, go to LAUNCH (pop as above); otherwise stay.
  - LAUNCH: tx_data_valid=1 for exactly this cycle; unconditionally go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise increment the timeout counter; when it reaches BUSY_TIMEOUT, set tx_err and go to IDLE (that byte is lost).
  - WAIT_DONE: stay while tx_busy=1; on tx_busy=0, go to IDLE.
  - Undefined state encodings return to IDLE.
- Outputs:
  - tx_data_valid is asserted only in LAUNCH.
  - tx_p_data is held constant from LAUNCH until the next LAUNCH, covering the whole TX frame.
- Latency:
  - Write at edge E0 into an empty FIFO with TX idle: tx_data_valid is high during E1..E2.
  - tx_busy falling in cycle C with data pending: the next tx_data_valid is high two cycles later (C+1 via IDLE, then LAUNCH).
- Flags:
  - clr_flags=1 clears overflow and tx_err at the edge.
  - If a set event and clr_flags coincide in the same cycle, the set wins.
- Reset mid-frame: all state is discarded, including FIFO contents and tx_p_data; tx_data_valid is 0 immediately.

Test Plan:
- Single byte: reset, write 0xA5 with tx_busy=0 and the TX model raising busy 1 cycle after valid for 20 cycles.
  -> One tx_data_valid pulse 1 cycle after the write; tx_p_data=0xA5 stable for all 20 busy cycles; empty=1 afterwards.
- Burst: write 0x01..0x08 back-to-back.
  -> full=1 after the 8th write, or fill_level=7 if the first byte was already launched.
  -> Bytes are launched in order 0x01..0x08, each valid exactly 2 cycles after the previous busy falls.
- Overflow: with tx_busy held 1, write 9 bytes (0x10..0x18).
  -> fill_level=8, overflow=1, 0x18 is never transmitted.
  -> clr_flags clears overflow.
- Wrap-around: 20 write/drain cycles of 3 bytes each with incrementing data.
  -> Transmitted sequence matches the written sequence with no loss or duplication across pointer wrap.
- Timeout: write 0x3C while the TX model never raises busy.
  -> tx_err=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry; FSM returns to IDLE; the next byte still launches.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE with 4 entries queued.
  -> Outputs go to their reset values asynchronously; after release, no tx_data_valid occurs until a new write.
